// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Helpers shared by the async FIFO read- and write-domain controllers:
//   pointer width derivation, binary/gray conversion, and the occupancy
//   states of the read-side FWFT output buffer.
//   No ports (package).
// -----------------------------------------------------------------------------
package fifo_pkg;

  // Conversions run at a fixed maximum width; callers cast to their own width.
  localparam int PTR_W_MAX = 32;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

  // Pointer width: address bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] b);
    return b ^ (b >> 1'b1);
  endfunction

  function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] g);
    logic [PTR_W_MAX-1:0] b;
    b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
    for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rd_ctrl_fwft_if.sv
// -----------------------------------------------------------------------------
// rd_ctrl_fwft_if
//   Signal bundle of the FIFO read-domain controller.
//   slave  : the controller (rd_ctrl_fwft)
//   master : its environment (consumer, write-pointer synchroniser, RAM)
//   Consumer : rd_rq, rdata, rvalid, empty, almost_empty, rlevel, underflow
//   Pointers : rsync_ptr2 (synchronised gray write ptr), rptr (gray read ptr)
//   RAM      : mem_ren, raddr, mem_rdata (valid the cycle after mem_ren)
// -----------------------------------------------------------------------------
interface rd_ctrl_fwft_if #(
  parameter int AW    = 4,
  parameter int WIDTH = 8
);
  logic             rd_rq;
  logic [AW:0]      rsync_ptr2;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ren;
  logic [AW-1:0]    raddr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             empty;
  logic             almost_empty;
  logic [AW:0]      rlevel;
  logic             underflow;

  modport slave (
    input  rd_rq, rsync_ptr2, mem_rdata,
    output mem_ren, raddr, rptr, rdata, rvalid, empty, almost_empty, rlevel, underflow
  );

  modport master (
    output rd_rq, rsync_ptr2, mem_rdata,
    input  mem_ren, raddr, rptr, rdata, rvalid, empty, almost_empty, rlevel, underflow
  );
endinterface

// File: rtl/rd_out_buf.sv
// -----------------------------------------------------------------------------
// rd_out_buf
//   Two-entry head/skid output buffer for first-word-fall-through reads.
//   occ (FSM state) counts buffered words plus the word in flight from RAM.
//   Ports: clk, rst_n, rd_rq (consumer pop), ram_empty, mem_rdata (in);
//          mem_ren, rdata (head word), rvalid (head valid), occ_nxt (out).
// -----------------------------------------------------------------------------
module rd_out_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_rq,
  input  logic             ram_empty,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_ren,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic [1:0]       occ_nxt
);

  occ_state_e       state_r;
  occ_state_e       state_nxt_s;
  logic [1:0]       occ_s;
  logic [1:0]       occ_nxt_s;
  logic             pop_s;
  logic             ren_s;
  logic             arr_r;
  logic             head_v_r;
  logic             skid_v_r;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] skid_r;

  assign pop_s = rd_rq & head_v_r;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= OCC_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next occupancy: one fetch in, one pop out per cycle.
  always_comb begin
    occ_nxt_s   = occ_s + {1'b0, ren_s} - {1'b0, pop_s};
    state_nxt_s = OCC_EMPTY;
    case (occ_nxt_s)
      2'd0:    state_nxt_s = OCC_EMPTY;
      2'd1:    state_nxt_s = OCC_ONE;
      2'd2:    state_nxt_s = OCC_TWO;
      default: state_nxt_s = OCC_EMPTY;
    endcase
  end

  // Outputs of the FSM: fetch only if a slot is still free after this cycle's pop.
  always_comb begin
    occ_s = 2'd0;
    case (state_r)
      OCC_EMPTY: occ_s = 2'd0;
      OCC_ONE:   occ_s = 2'd1;
      OCC_TWO:   occ_s = 2'd2;
      default:   occ_s = 2'd0;
    endcase
    ren_s = ~ram_empty & ((occ_s - {1'b0, pop_s}) < 2'd2);
  end

  // Head/skid datapath: the skid word has priority over the arriving word on a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr_r    <= 1'b0;
      head_v_r <= 1'b0;
      skid_v_r <= 1'b0;
      head_r   <= '0;
      skid_r   <= '0;
    end else begin
      arr_r <= ren_s;
      if (pop_s) begin
        if (skid_v_r) begin
          head_r <= skid_r;
          if (arr_r) begin
            skid_r <= mem_rdata;
          end else begin
            skid_v_r <= 1'b0;
          end
        end else if (arr_r) begin
          head_r <= mem_rdata;
        end else begin
          head_v_r <= 1'b0;
        end
      end else if (arr_r) begin
        if (head_v_r) begin
          skid_r   <= mem_rdata;
          skid_v_r <= 1'b1;
        end else begin
          head_r   <= mem_rdata;
          head_v_r <= 1'b1;
        end
      end
    end
  end

  assign mem_ren = ren_s;
  assign rdata   = head_r;
  assign rvalid  = head_v_r;
  assign occ_nxt = occ_nxt_s;

endmodule

// File: rtl/rd_ctrl_fwft.sv
// -----------------------------------------------------------------------------
// rd_ctrl_fwft
//   Read-domain controller of the async FIFO: binary/gray read pointer,
//   registered empty, read level, almost_empty, underflow pulse and an
//   optional first-word-fall-through output stage (FWFT=1).
//   Ports: r_clk (only clock), rst_n (async active-low),
//          bus (rd_ctrl_fwft_if.slave: consumer, pointer and RAM signals).
// -----------------------------------------------------------------------------
module rd_ctrl_fwft
  import fifo_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic          r_clk,
  input  logic          rst_n,
  rd_ctrl_fwft_if.slave bus
);

  localparam int            PW     = ptr_w(DEPTH);
  localparam int            AW     = PW - 1;
  localparam logic [PW-1:0] AE_LIM = PW'(AE_THRESH);

  logic [PW-1:0]    rbin_r;
  logic [PW-1:0]    rptr_r;
  logic [PW-1:0]    rlevel_r;
  logic             ram_empty_r;
  logic             almost_empty_r;
  logic             underflow_r;
  logic [PW-1:0]    wbin_s;
  logic [PW-1:0]    rbin_nxt_s;
  logic [PW-1:0]    rgray_nxt_s;
  logic [PW-1:0]    rlevel_nxt_s;
  logic             mem_ren_s;
  logic             rvalid_s;
  logic             empty_s;
  logic             underflow_nxt_s;
  logic [WIDTH-1:0] rdata_s;
  logic [1:0]       occ_nxt_s;

  assign wbin_s       = PW'(gray2bin(PTR_W_MAX'(bus.rsync_ptr2)));
  assign rbin_nxt_s   = rbin_r + PW'(mem_ren_s);
  assign rgray_nxt_s  = PW'(bin2gray(PTR_W_MAX'(rbin_nxt_s)));
  // Level counts every word not yet handed to the consumer, including buffered ones.
  assign rlevel_nxt_s = wbin_s - rbin_nxt_s + PW'(occ_nxt_s);

  generate
    if (FWFT != 0) begin : g_fwft
      rd_out_buf #(.WIDTH(WIDTH)) u_out_buf (
        .clk       (r_clk),
        .rst_n     (rst_n),
        .rd_rq     (bus.rd_rq),
        .ram_empty (ram_empty_r),
        .mem_rdata (bus.mem_rdata),
        .mem_ren   (mem_ren_s),
        .rdata     (rdata_s),
        .rvalid    (rvalid_s),
        .occ_nxt   (occ_nxt_s)
      );
      assign empty_s         = ~rvalid_s;
      assign underflow_nxt_s = bus.rd_rq & ~rvalid_s;
    end else begin : g_std
      logic             rvalid_r;
      logic [WIDTH-1:0] hold_r;

      assign mem_ren_s = bus.rd_rq & ~ram_empty_r;

      // rvalid follows the RAM read latency; hold_r keeps rdata steady between words.
      always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
          rvalid_r <= 1'b0;
          hold_r   <= '0;
        end else begin
          rvalid_r <= mem_ren_s;
          if (rvalid_r) begin
            hold_r <= bus.mem_rdata;
          end
        end
      end

      assign rvalid_s        = rvalid_r;
      assign rdata_s         = rvalid_r ? bus.mem_rdata : hold_r;
      assign empty_s         = ram_empty_r;
      assign underflow_nxt_s = bus.rd_rq & ram_empty_r;
      assign occ_nxt_s       = 2'd0;
    end
  endgenerate

  // Read pointer, RAM-empty, level and status flags.
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin_r         <= '0;
      rptr_r         <= '0;
      ram_empty_r    <= 1'b1;
      rlevel_r       <= '0;
      almost_empty_r <= 1'b1;
      underflow_r    <= 1'b0;
    end else begin
      rbin_r         <= rbin_nxt_s;
      rptr_r         <= rgray_nxt_s;
      ram_empty_r    <= (rgray_nxt_s == bus.rsync_ptr2);
      rlevel_r       <= rlevel_nxt_s;
      almost_empty_r <= (rlevel_nxt_s <= AE_LIM);
      underflow_r    <= underflow_nxt_s;
    end
  end

  assign bus.mem_ren      = mem_ren_s;
  assign bus.raddr        = rbin_r[AW-1:0];
  assign bus.rptr         = rptr_r;
  assign bus.rdata        = rdata_s;
  assign bus.rvalid       = rvalid_s;
  assign bus.empty        = empty_s;
  assign bus.almost_empty = almost_empty_r;
  assign bus.rlevel       = rlevel_r;
  assign bus.underflow    = underflow_r;

endmodule

// File: tb/tb_rd_ctrl_fwft.sv
// -----------------------------------------------------------------------------
// tb_rd_ctrl_fwft
//   Drives a standard-mode and an FWFT-mode controller side by side with
//   random writes/reads and compares every cycle against a word-count/queue
//   model of the FIFO read side.
// -----------------------------------------------------------------------------
module tb_rd_ctrl_fwft;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rd_ctrl_fwft_if #(.AW(4), .WIDTH(8)) bus0 ();
  rd_ctrl_fwft_if #(.AW(4), .WIDTH(8)) bus1 ();

  logic       rd_rq_a [2];
  logic [4:0] wg_a    [2];
  logic [7:0] mrd_a   [2];

  assign bus0.rd_rq      = rd_rq_a[0];
  assign bus0.rsync_ptr2 = wg_a[0];
  assign bus0.mem_rdata  = mrd_a[0];
  assign bus1.rd_rq      = rd_rq_a[1];
  assign bus1.rsync_ptr2 = wg_a[1];
  assign bus1.mem_rdata  = mrd_a[1];

  rd_ctrl_fwft #(.DEPTH(16), .WIDTH(8), .AE_THRESH(2), .FWFT(0)) u_std (
    .r_clk (clk), .rst_n (rst_n), .bus (bus0)
  );
  rd_ctrl_fwft #(.DEPTH(16), .WIDTH(8), .AE_THRESH(2), .FWFT(1)) u_fwft (
    .r_clk (clk), .rst_n (rst_n), .bus (bus1)
  );

  // Dual-port RAMs: one-cycle read latency.
  logic [7:0] ram [2][16];
  always @(posedge clk) begin
    if (bus0.mem_ren) mrd_a[0] <= ram[0][bus0.raddr];
    if (bus1.mem_ren) mrd_a[1] <= ram[1][bus1.raddr];
  end

  // Reference model: counts of words written / visible / fetched, plus output queues.
  int         wcnt [2];
  int         seen [2];
  int         fetched [2];
  int         cyc;
  logic [7:0] hist [2][4096];
  logic       pv [2];
  logic [7:0] pd [2];
  logic       uf [2];
  logic [7:0] q_d [$];
  int         q_t [$];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      wcnt[m] = 0; seen[m] = 0; fetched[m] = 0;
      pv[m] = 1'b0; pd[m] = 8'h00; uf[m] = 1'b0;
      rd_rq_a[m] = 1'b0; wg_a[m] = 5'd0;
    end
    q_d.delete();
    q_t.delete();
  endtask

  task automatic check_and_step(input int m, input bit do_step);
    int         avail;
    int         e_lvl;
    logic       rq, pop, e_ren, e_rv, e_empty;
    logic [7:0] e_rd;
    logic       a_ren, a_rv, a_emp, a_ae, a_uf;
    logic [3:0] a_ra;
    logic [4:0] a_rp, a_lv;
    logic [7:0] a_rd;
    string      p;
    avail = seen[m] - fetched[m];
    rq    = rd_rq_a[m];
    pop   = 1'b0;
    if (m == 0) begin
      p = "std/";
      e_ren = rq && (avail > 0); e_rv = pv[0]; e_rd = pd[0];
      e_empty = (avail == 0); e_lvl = avail;
      a_ren = bus0.mem_ren; a_rv = bus0.rvalid; a_emp = bus0.empty; a_ae = bus0.almost_empty;
      a_uf = bus0.underflow; a_ra = bus0.raddr; a_rp = bus0.rptr; a_lv = bus0.rlevel; a_rd = bus0.rdata;
    end else begin
      p = "fwft/";
      e_rv = (q_d.size() > 0) && (q_t[0] <= cyc);
      pop = rq && e_rv;
      e_ren = (avail > 0) && ((q_d.size() - int'(pop)) < 2);
      e_rd = e_rv ? q_d[0] : 8'h00;
      e_empty = !e_rv; e_lvl = avail + q_d.size();
      a_ren = bus1.mem_ren; a_rv = bus1.rvalid; a_emp = bus1.empty; a_ae = bus1.almost_empty;
      a_uf = bus1.underflow; a_ra = bus1.raddr; a_rp = bus1.rptr; a_lv = bus1.rlevel; a_rd = bus1.rdata;
    end
    check_val({p, "mem_ren"}, 32'(a_ren), 32'(e_ren));
    check_val({p, "raddr"}, 32'(a_ra), 32'(fetched[m] % 16));
    check_val({p, "rptr"}, 32'(a_rp), 32'(gray5(fetched[m])));
    check_val({p, "empty"}, 32'(a_emp), 32'(e_empty));
    check_val({p, "rlevel"}, 32'(a_lv), 32'(e_lvl));
    check_val({p, "almost_empty"}, 32'(a_ae), 32'(e_lvl <= 2));
    check_val({p, "rvalid"}, 32'(a_rv), 32'(e_rv));
    check_val({p, "underflow"}, 32'(a_uf), 32'(uf[m]));
    if (e_rv) check_val({p, "rdata"}, 32'(a_rd), 32'(e_rd));
    if (do_step) begin
      if (m == 0) begin
        uf[0] = rq && (avail == 0);
        if (e_ren) begin
          pd[0] = hist[0][fetched[0]]; pv[0] = 1'b1; fetched[0]++;
        end else begin
          pv[0] = 1'b0;
        end
      end else begin
        uf[1] = rq && !e_rv;
        if (pop) begin
          void'(q_d.pop_front()); void'(q_t.pop_front());
        end
        if (e_ren) begin
          q_d.push_back(hist[1][fetched[1]]); q_t.push_back(cyc + 2); fetched[1]++;
        end
      end
      seen[m] = wcnt[m];
    end
  endtask

  task automatic run_cycle(input int rd_pct, input int wr_pct);
    logic [7:0] d;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      if ((wcnt[m] - fetched[m] < 16) && (wcnt[m] < 4095) && ($urandom_range(99) < wr_pct)) begin
        d = 8'($urandom);
        ram[m][wcnt[m] % 16] = d;
        hist[m][wcnt[m]] = d;
        wcnt[m]++;
        wg_a[m] = gray5(wcnt[m]);
      end
      rd_rq_a[m] = ($urandom_range(99) < rd_pct);
    end
    #1;
    for (int m = 0; m < 2; m++) check_and_step(m, 1'b1);
    cyc++;
  endtask

  task automatic run_phase(input int n, input int rd_pct, input int wr_pct);
    for (int i = 0; i < n; i++) run_cycle(rd_pct, wr_pct);
  endtask

  task automatic reset_checks();
    for (int m = 0; m < 2; m++) check_and_step(m, 1'b0);
    check_val("std/rdata_rst", 32'(bus0.rdata), 32'h0);
    check_val("fwft/rdata_rst", 32'(bus1.rdata), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    cyc = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1 reset_checks();
    @(negedge clk);
    rst_n = 1'b1;

    run_phase(4, 0, 0);        // idle after reset
    run_phase(3, 0, 100);      // three words
    run_phase(6, 100, 0);      // held read, then underflow
    run_phase(24, 0, 100);     // fill to full
    run_phase(24, 100, 0);     // drain through threshold into empty
    run_phase(400, 60, 60);
    run_phase(300, 30, 90);
    run_phase(300, 90, 30);
    run_phase(60, 100, 100);   // sustained streaming
    run_phase(30, 100, 0);
    run_phase(6, 0, 100);      // FWFT buffer fills to two words

    // Asynchronous reset in the middle of a cycle with the buffer full.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("fwft/rvalid_async_rst", 32'(bus1.rvalid), 32'h0);
    check_val("fwft/empty_async_rst", 32'(bus1.empty), 32'h1);
    check_val("std/rvalid_async_rst", 32'(bus0.rvalid), 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    #1 reset_checks();
    @(negedge clk);
    rst_n = 1'b1;
    run_phase(8, 50, 0);       // no stale data after release
    run_phase(200, 50, 50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
